lvds_8b10b_send: RTL and testbench
==================================

Name: lvds_8b10b_send

Overview:
- Frame-based 8b/10b serializer feeding one LVDS transmit pin; one serial bit per clk.
- Each frame: K28.5 comma, then NUM_BYTES encoded data characters.
- Captures a parallel word once per frame and pulses data_read_o so upstream can present the next word.
- Sits between a parallel data source and the LVDS output buffer.

Parameters:
- NUM_BYTES, 2, data bytes per frame (>=1); frame length = 10*(NUM_BYTES+1) clk cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data  input  8*NUM_BYTES  parallel word; byte 0 = data[7:0] is sent first.
- data_read_o  output  1  one-cycle pulse; data was captured on the edge that raised it.
- serial_o  output  1  serial 8b/10b bit stream.

Behaviour:
- Reset values: data_read_o=0, serial_o=0, running disparity RD=-, bit counter=0, char counter=0.
- First rising edge after reset deasserts:
  - capture data into holding register;
  - set data_read_o=1 for exactly one cycle;
  - load K28.5 for current RD;
  - serial_o = comma bit a in that same cycle.
- Character bit order: a,b,c,d,e,i,f,g,h,j (a first). All outputs are registered.
- Frame sequence: comma, byte0, byte1 … byte(NUM_BYTES-1), then immediately next comma with new capture. No idle gaps.
- Period: data_read_o period = 10*(NUM_BYTES+1) cycles.
- Upstream data timing:
  - data may change any time after a data_read_o pulse;
  - it must be stable at the next capture edge;
  - the value captured at frame N is transmitted in frame N.
- K28.5 codes: RD-=0011111010, RD+=1100000101. Both flip RD.
- Data characters: standard IEEE 8b/10b 5b/6b + 3b/4b with running disparity.
  - Include D.x.A7 alternate (111→0111/1000) rules.
  - Include D.07 and 3b/4b disparity selection by sub-block RD.
  - RD updates after each 6b and 4b sub-block.
- Each character is encoded and loaded into a 10-bit shift register at the edge its bit a is output (encode combinationally from the holding register, or pre-encode during the prior character). serial_o never glitches between characters.
- Counters: bit counter 0..9; character counter 0..NUM_BYTES, wrapping to 0 (comma) after the last byte.
- Reset mid-frame aborts immediately:
  - outputs return to reset values, RD=-;
  - the next frame starts with a fresh capture.
- Clock enable: none. Every cycle emits a bit.

Optional Feature:
- Macro: LVDS_8B10B_SEND_INVERT_EN.
- Defined: serial_o is the logical inverse of the encoded stream (swapped LVDS pair); serial_o resets to 1.
- Undefined: serial_o is the true encoded stream; resets to 0.
- Encoding, RD and data_read_o timing are identical in both builds.

Decomposition:
- Package lvds_8b10b_pkg:
  - SYMBOL_BITS=10;
  - K28_5_RDN=10'b0011111010, K28_5_RDP=10'b1100000101;
  - RD encoding constants.
- Sub-module enc_8b10b (combinational):
  - inputs: byte, is_k, rd_in;
  - outputs: code[9:0] (a at bit 0), rd_out;
  - used for both comma and data characters.

Test Plan:
- Reset held 10 cycles (NUM_BYTES=2) → serial_o=0, data_read_o=0 throughout; first pulse on first edge after release.
- Steady state, NUM_BYTES=2 → data_read_o pulses exactly every 30 cycles, width 1 cycle.
- data=16'h0001 captured, RD- at frame start → serial bits: 0011111010 (K28.5) then 1000101011 (D1.0) then 0110001011 (D0.0); next comma at RD+ = 1100000101.
- data=16'habcd over consecutive frames, upstream updating one cycle after each pulse → decoded stream returns cd, ab per frame; RD never violates ±1 and no run exceeds 5 identical bits.
- Assert reset in mid-byte, release → stream restarts with RD- comma 0011111010 and a new data_read_o pulse on the first edge.
- LVDS_8B10B_SEND_INVERT_EN defined → serial_o=1 in reset; first comma emitted as 1100000101.

Source files
------------

// File: rtl/lvds_8b10b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lvds_8b10b_pkg
// Description : Shared constants for the 8b/10b LVDS frame serializer.
//               Symbol width, K28.5 comma codes and running-disparity
//               encoding. Comma literals are written in transmission order
//               abcdeifghj, so bit 9 of each literal is bit a.
// Revision    : 1.0 - initial release
// ============================================================================
package lvds_8b10b_pkg;

  localparam int SYMBOL_BITS = 10;

  // Running disparity: 0 = RD-, 1 = RD+
  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  // K28.5 comma, written a..j from MSB to LSB
  localparam logic [SYMBOL_BITS-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYMBOL_BITS-1:0] K28_5_RDP = 10'b1100000101;

  // Converts an abcdeifghj literal (a at MSB) to wire order (a at bit 0)
  function automatic logic [SYMBOL_BITS-1:0] bitrev10(input logic [SYMBOL_BITS-1:0] v);
    logic [SYMBOL_BITS-1:0] r;
    for (int n = 0; n < SYMBOL_BITS; n++) begin
      r[n] = v[SYMBOL_BITS-1-n];
    end
    return r;
  endfunction

endpackage : lvds_8b10b_pkg
`default_nettype wire

// File: rtl/lvds_8b10b_send_enc.sv
`default_nettype none
// ============================================================================
// Module      : enc_8b10b
// Description : Combinational 8b/10b character encoder with running
//               disparity. The 6b and 4b sub-blocks are each chosen by the
//               disparity that is current when they are sent. D.x.A7 and D.07
//               are included. i_is_k selects the K28.5 comma, which is the
//               only control character this link uses.
// Ports       : i_byte  - data byte, HGF EDCBA
//               i_is_k  - 1: emit K28.5 instead of data
//               i_rd    - running disparity in (1 = RD+)
//               o_code  - 10-bit character, bit a at o_code[0]
//               o_rd    - running disparity after the character
// Revision    : 1.0 - initial release
// ============================================================================
module enc_8b10b
  import lvds_8b10b_pkg::*;
(
  input  logic                   i_byte_dummy_unused_guard, // tied off in top
  input  logic [7:0]             i_byte,
  input  logic                   i_is_k,
  input  logic                   i_rd,
  output logic [SYMBOL_BITS-1:0] o_code,
  output logic                   o_rd
);

  logic [4:0] w_x;
  logic [2:0] w_y;
  logic [5:0] w_base6;
  logic [5:0] w_six;
  logic       w_bal6;
  logic       w_rd6;
  logic       w_use_a7;
  logic [3:0] w_base4;
  logic [3:0] w_four;
  logic       w_bal4;
  logic [SYMBOL_BITS-1:0] w_code_msb;

  assign w_x = i_byte[4:0];
  assign w_y = i_byte[7:5];

  // 5b/6b: RD- column in abcdei order; RD+ is the complement for
  // unbalanced codes and identical for balanced ones (D.07 handled below).
  always_comb begin
    w_base6 = 6'b000000;
    case (w_x)
      5'd0:  w_base6 = 6'b100111;
      5'd1:  w_base6 = 6'b011101;
      5'd2:  w_base6 = 6'b101101;
      5'd3:  w_base6 = 6'b110001;
      5'd4:  w_base6 = 6'b110101;
      5'd5:  w_base6 = 6'b101001;
      5'd6:  w_base6 = 6'b011001;
      5'd7:  w_base6 = 6'b111000;
      5'd8:  w_base6 = 6'b111001;
      5'd9:  w_base6 = 6'b100101;
      5'd10: w_base6 = 6'b010101;
      5'd11: w_base6 = 6'b110100;
      5'd12: w_base6 = 6'b001101;
      5'd13: w_base6 = 6'b101100;
      5'd14: w_base6 = 6'b011100;
      5'd15: w_base6 = 6'b010111;
      5'd16: w_base6 = 6'b011011;
      5'd17: w_base6 = 6'b100011;
      5'd18: w_base6 = 6'b010011;
      5'd19: w_base6 = 6'b110010;
      5'd20: w_base6 = 6'b001011;
      5'd21: w_base6 = 6'b101010;
      5'd22: w_base6 = 6'b011010;
      5'd23: w_base6 = 6'b111010;
      5'd24: w_base6 = 6'b110011;
      5'd25: w_base6 = 6'b100110;
      5'd26: w_base6 = 6'b010110;
      5'd27: w_base6 = 6'b110110;
      5'd28: w_base6 = 6'b001110;
      5'd29: w_base6 = 6'b101110;
      5'd30: w_base6 = 6'b011110;
      5'd31: w_base6 = 6'b101011;
      default: w_base6 = 6'b000000;
    endcase
  end

  always_comb begin
    w_bal6 = ($countones(w_base6) == 3);
    if (w_x == 5'd7) begin
      // D.07 is balanced but still has a disparity-dependent form
      w_six = (i_rd == RD_POS) ? 6'b000111 : 6'b111000;
    end else if (!w_bal6 && (i_rd == RD_POS)) begin
      w_six = ~w_base6;
    end else begin
      w_six = w_base6;
    end
    w_rd6 = i_rd ^ ~w_bal6;
  end

  // A7 avoids a run of five equal bits across the e/i-f boundary
  assign w_use_a7 = (w_y == 3'd7) &&
                    (((w_rd6 == RD_NEG) && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) ||
                     ((w_rd6 == RD_POS) && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14))));

  // 3b/4b: RD- column in fghj order
  always_comb begin
    w_base4 = 4'b0000;
    case (w_y)
      3'd0: w_base4 = 4'b1011;
      3'd1: w_base4 = 4'b1001;
      3'd2: w_base4 = 4'b0101;
      3'd3: w_base4 = 4'b1100;
      3'd4: w_base4 = 4'b1101;
      3'd5: w_base4 = 4'b1010;
      3'd6: w_base4 = 4'b0110;
      3'd7: w_base4 = w_use_a7 ? 4'b0111 : 4'b1110;
      default: w_base4 = 4'b0000;
    endcase
  end

  always_comb begin
    w_bal4 = ($countones(w_base4) == 2);
    if (w_y == 3'd3) begin
      w_four = (w_rd6 == RD_POS) ? 4'b0011 : 4'b1100;
    end else if (!w_bal4 && (w_rd6 == RD_POS)) begin
      w_four = ~w_base4;
    end else begin
      w_four = w_base4;
    end
  end

  always_comb begin
    w_code_msb = {w_six, w_four};
    o_rd       = w_rd6 ^ ~w_bal4;
    if (i_is_k) begin
      w_code_msb = (i_rd == RD_POS) ? K28_5_RDP : K28_5_RDN;
      o_rd       = ~i_rd;
    end
    o_code = bitrev10(w_code_msb);
  end

endmodule : enc_8b10b
`default_nettype wire

// File: rtl/lvds_8b10b_send.sv
`default_nettype none
// ============================================================================
// Module      : lvds_8b10b_send
// Description : Frame-based 8b/10b serializer for one LVDS transmit pin.
//               A frame is a K28.5 comma followed by NUM_BYTES data
//               characters, one serial bit per clk, no idle gaps. The
//               parallel word is captured on the edge that starts each
//               comma, and data_read_o pulses in the following cycle.
// Ports       : clk         - system clock, rising edge
//               reset       - asynchronous, active-high
//               data        - parallel word, byte 0 (data[7:0]) sent first
//               data_read_o - one-cycle pulse: data captured on that edge
//               serial_o    - serial stream, bit a of each character first
// Options     : LVDS_8B10B_SEND_INVERT_EN - when defined, serial_o carries
//               the inverted stream (swapped LVDS pair) and resets to 1.
// Revision    : 1.0 - initial release
// ============================================================================
module lvds_8b10b_send
  import lvds_8b10b_pkg::*;
#(
  parameter int NUM_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*NUM_BYTES-1:0] data,
  output logic                   data_read_o,
  output logic                   serial_o
);

`ifdef LVDS_8B10B_SEND_INVERT_EN
  localparam logic c_invert = 1'b1;
`else
  localparam logic c_invert = 1'b0;
`endif

  localparam int CW = (NUM_BYTES < 2) ? 1 : $clog2(NUM_BYTES + 1);
  localparam logic [3:0]    c_last_bit  = 4'(SYMBOL_BITS - 1);
  localparam logic [CW-1:0] c_last_char = CW'(NUM_BYTES);

  logic [3:0]               bit_cnt_q,  bit_cnt_d;
  logic [CW-1:0]            char_cnt_q, char_cnt_d;
  logic [8*NUM_BYTES-1:0]   hold_q,     hold_d;
  logic [SYMBOL_BITS-2:0]   shreg_q,    shreg_d;
  logic                     rd_q,       rd_d;
  logic                     data_read_q, data_read_d;
  logic                     serial_q,   serial_d;

  logic [7:0]               w_byte;
  logic                     w_is_k;
  logic [SYMBOL_BITS-1:0]   w_code;
  logic                     w_rd_out;
  logic                     w_tx_bit;

  // Character 0 is the comma; character k>0 carries hold byte k-1
  always_comb begin
    w_byte = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (char_cnt_q == CW'(i + 1)) begin
        w_byte = hold_q[i*8 +: 8];
      end
    end
  end

  assign w_is_k = (char_cnt_q == '0);

  enc_8b10b u_enc (
    .i_byte_dummy_unused_guard (1'b0),
    .i_byte                    (w_byte),
    .i_is_k                    (w_is_k),
    .i_rd                      (rd_q),
    .o_code                    (w_code),
    .o_rd                      (w_rd_out)
  );

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    char_cnt_d  = char_cnt_q;
    hold_d      = hold_q;
    shreg_d     = shreg_q;
    rd_d        = rd_q;
    data_read_d = 1'b0;
    w_tx_bit    = shreg_q[0];

    if (bit_cnt_q == 4'd0) begin
      // Load the whole character: bit a goes out now, b..j queue behind it
      w_tx_bit = w_code[0];
      shreg_d  = w_code[SYMBOL_BITS-1:1];
      rd_d     = w_rd_out;
      if (char_cnt_q == '0) begin
        hold_d      = data;
        data_read_d = 1'b1;
      end
    end else begin
      shreg_d = {1'b0, shreg_q[SYMBOL_BITS-2:1]};
    end

    if (bit_cnt_q == c_last_bit) begin
      bit_cnt_d  = 4'd0;
      char_cnt_d = (char_cnt_q == c_last_char) ? '0 : char_cnt_q + 1'b1;
    end else begin
      bit_cnt_d = bit_cnt_q + 4'd1;
    end

    serial_d = w_tx_bit ^ c_invert;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q   <= 4'd0;
      char_cnt_q  <= '0;
      hold_q      <= '0;
      shreg_q     <= '0;
      rd_q        <= RD_NEG;
      data_read_q <= 1'b0;
      serial_q    <= c_invert;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      char_cnt_q  <= char_cnt_d;
      hold_q      <= hold_d;
      shreg_q     <= shreg_d;
      rd_q        <= rd_d;
      data_read_q <= data_read_d;
      serial_q    <= serial_d;
    end
  end

  assign data_read_o = data_read_q;
  assign serial_o    = serial_q;

endmodule : lvds_8b10b_send
`default_nettype wire

// File: tb/tb_lvds_8b10b_send.sv
`default_nettype none
// ============================================================================
// Module      : tb_lvds_8b10b_send
// Description : Scoreboard bench for lvds_8b10b_send with NUM_BYTES=2.
//               Stimulus pushes hand-computed characters (abcdeifghj, a at
//               MSB) for each frame it offers; the monitor aligns on
//               data_read_o, assembles 10-bit characters from serial_o and
//               compares them, and also checks pulse period and run length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lvds_8b10b_send;

  localparam int NB = 2;

`ifdef LVDS_8B10B_SEND_INVERT_EN
  localparam logic [9:0] INV_MASK = 10'h3FF;
  localparam logic       RST_SER  = 1'b1;
`else
  localparam logic [9:0] INV_MASK = 10'h000;
  localparam logic       RST_SER  = 1'b0;
`endif

  // Hand-computed characters
  localparam logic [9:0] K_N    = 10'b0011111010; // K28.5 RD-
  localparam logic [9:0] K_P    = 10'b1100000101; // K28.5 RD+
  localparam logic [9:0] D1_0P  = 10'b1000101011; // D1.0 at RD+
  localparam logic [9:0] D0_0P  = 10'b0110001011; // D0.0 at RD+
  localparam logic [9:0] D13_6  = 10'b1011000110; // D13.6 either RD
  localparam logic [9:0] D11_5  = 10'b1101001010; // D11.5 either RD
  localparam logic [9:0] D17_7N = 10'b1000110111; // D17.A7 at RD-
  localparam logic [9:0] D7_0P  = 10'b0001110100; // D7.0 at RD+

  logic            clk = 1'b0;
  logic            reset;
  logic [8*NB-1:0] data;
  logic            data_read_o;
  logic            serial_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_q[$];

  lvds_8b10b_send #(.NUM_BYTES(NB)) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .data_read_o (data_read_o),
    .serial_o    (serial_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [9:0] c0, input logic [9:0] c1, input logic [9:0] c2);
    exp_q.push_back(c0);
    exp_q.push_back(c1);
    exp_q.push_back(c2);
  endtask

  task automatic wait_pulse(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (data_read_o) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  // ---------------- monitor ----------------
  logic [9:0] mon_got;
  logic [9:0] mon_exp;
  int  mon_idx, mon_cyc, mon_run;
  bit  mon_active, mon_have_prev;
  logic mon_last;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      mon_active    = 1'b0;
      mon_have_prev = 1'b0;
      mon_idx       = 0;
      mon_cyc       = 0;
      mon_run       = 0;
    end else begin
      if (data_read_o) begin
        if (mon_have_prev) chk("pulse_period", 32'(mon_cyc), 32'd30);
        mon_have_prev = 1'b1;
        mon_cyc       = 0;
        mon_active    = 1'b1;
        mon_idx       = 0;
      end
      if (mon_active) begin
        mon_got = {mon_got[8:0], serial_o};
        if (mon_run > 0 && serial_o == mon_last) mon_run++;
        else mon_run = 1;
        mon_last = serial_o;
        n_checks++;
        if (mon_run > 5) begin
          n_errors++;
          $display("FAIL run_length: got %0d expected <=5 at %0t", mon_run, $time);
        end
        mon_idx++;
        if (mon_idx == 10) begin
          mon_idx = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_char", 32'(mon_got), 32'h3FF_FFFF);
          end else begin
            mon_exp = exp_q.pop_front();
            chk("char", 32'(mon_got), 32'(mon_exp ^ INV_MASK));
          end
        end
      end
      mon_cyc++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    data  = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_serial", {31'd0, serial_o}, {31'd0, RST_SER});
      chk("reset_pulse",  {31'd0, data_read_o}, 32'd0);
    end
    @(posedge clk);
    #2;
    push_frame(K_N, D1_0P, D0_0P);          // ends RD+
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("first_pulse", {31'd0, data_read_o}, 32'd1);
    chk("first_bit",   {31'd0, serial_o}, {31'd0, RST_SER});   // comma bit a is 0
    wait_pulse("pulse_f0");

    @(posedge clk); #1;
    data = 16'habcd;
    push_frame(K_P, D13_6, D11_5);          // ends RD-
    wait_pulse("pulse_f1");

    @(posedge clk); #1;
    data = 16'habcd;
    push_frame(K_N, D13_6, D11_5);          // ends RD+
    wait_pulse("pulse_f2");

    @(posedge clk); #1;
    data = 16'h07F1;
    push_frame(K_P, D17_7N, D7_0P);         // ends RD-
    wait_pulse("pulse_f3");

    @(posedge clk); #1;
    data = 16'h0001;
    push_frame(K_N, D1_0P, D0_0P);          // ends RD+
    wait_pulse("pulse_f4");

    // Abort in the middle of the first data character of frame 4
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midreset_serial", {31'd0, serial_o}, {31'd0, RST_SER});
      chk("midreset_pulse",  {31'd0, data_read_o}, 32'd0);
    end
    @(posedge clk);
    #2;
    push_frame(K_N, D1_0P, D0_0P);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_pulse", {31'd0, data_read_o}, 32'd1);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_lvds_8b10b_send
`default_nettype wire
